dct8_transpose_mem: RTL and testbench

// - Transpose memory between row-pass and column-pass dct8_block instances of the 2-D 8x8 DCT.
// - Accepts 8 row-DCT result vectors (N coefficients each, one vector per transfer).
// - Emits the 8 columns of that 8x8 block as vectors to the column-pass stage.
// - Storage is flop-based; valid/ready handshake on both sides.

---
 rtl/dct8_transpose_mem.sv | 183 ++++++++++++++++++
 tb/tb_dct8_transpose_mem.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct8_transpose_mem.sv
// 8x8 transpose buffer between the row-pass and column-pass DCT stages.
// Optional DCT8_TPOSE_PINGPONG_EN: two banks so one block fills while the other drains.
module dct8_transpose_mem #(
  parameter int N = 8,   // only 8 is supported: counters are fixed at 3 bits
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,        // asynchronous, active-high
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_col,
  output logic           out_last,
  output logic [3:0]     dbg_state_o
);

  // Handshake: a transfer happens on the rising clk edge where valid && ready.
  // Once raised, out_valid holds and out_col is stable until its transfer completes;
  // in_valid seen while in_ready is low is ignored and its data is not captured.

  logic           in_fire;
  logic           out_fire;
  logic [N*W-1:0] col_data;
  logic [2:0]     wr_row_q, wr_row_d;
  logic [2:0]     rd_col_q, rd_col_d;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef DCT8_TPOSE_PINGPONG_EN

  logic [W-1:0] mem_q [2][N][N];
  logic         run_q, run_d;
  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
  logic [1:0]   full_q, full_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      run_q     <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      wr_row_q  <= 3'd0;
      rd_col_q  <= 3'd0;
    end else begin
      run_q     <= run_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
    end
  end

  // Fill of one bank and drain of the other touch different full bits, so both may land on one edge.
  always_comb begin
    run_d     = 1'b1;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;
    in_ready  = run_q && !full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    if (in_valid && in_ready) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (out_valid && out_ready) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int j = 0; j < N; j++) begin
        mem_q[wr_bank_q][wr_row_q][j] <= in_row[j*W +: W];
      end
    end
  end

  always_comb begin
    col_data = '0;
    for (int i = 0; i < N; i++) begin
      col_data[i*W +: W] = mem_q[rd_bank_q][i][rd_col_q];
    end
  end

  assign dbg_state_o = {full_q, wr_bank_q, rd_bank_q};

`else

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] mem_q [N][N];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      wr_row_q <= 3'd0;
      rd_col_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      wr_row_q <= wr_row_d;
      rd_col_q <= rd_col_d;
    end
  end

  // ST_IDLE holds in_ready low for the first edge after reset release.
  always_comb begin
    state_d   = state_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d  = ST_FILL;
        wr_row_d = 3'd0;
      end
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_row_d = wr_row_q + 3'd1;
          if (wr_row_q == 3'd7) begin
            state_d  = ST_DRAIN;
            rd_col_d = 3'd0;
          end
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rd_col_d = rd_col_q + 3'd1;
          if (rd_col_q == 3'd7) begin
            state_d  = ST_FILL;
            wr_row_d = 3'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int j = 0; j < N; j++) begin
        mem_q[wr_row_q][j] <= in_row[j*W +: W];
      end
    end
  end

  always_comb begin
    col_data = '0;
    for (int i = 0; i < N; i++) begin
      col_data[i*W +: W] = mem_q[i][rd_col_q];
    end
  end

  assign dbg_state_o = {2'b00, state_q};

`endif

  // Gate with out_valid so the output reads zero in reset and never shows stale storage.
  assign out_col  = out_valid ? col_data : '0;
  assign out_last = out_valid && (rd_col_q == 3'd7);

endmodule

// File: tb/tb_dct8_transpose_mem.sv
// Bench for dct8_transpose_mem: randomized and directed blocks against a queue-based transpose model.
// Builds for either configuration of DCT8_TPOSE_PINGPONG_EN.
module tb_dct8_transpose_mem;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int NW = N * W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_row;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] out_col;
  logic          out_last;
  logic [3:0]    dbg_state;

  dct8_transpose_mem #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_col     (out_col),
    .out_last    (out_last),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q: columns of completed blocks not yet emitted; row_q: rows of the block being filled.
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] row_q[$];
  bit            run = 1'b0;
  int            n_cols = 0;

  function automatic logic [NW-1:0] column_of(input int c);
    logic [NW-1:0] col;
    logic [NW-1:0] rr;
    col = '0;
    for (int i = 0; i < N; i++) begin
      rr = row_q[i];
      col[i*W +: W] = rr[c*W +: W];
    end
    return col;
  endfunction

  always @(negedge clk) begin
    int  pend;
    bit  e_ready;
    bit  e_valid;
    bit  e_last;
    if (rst_n) begin
      check("rst_in_ready", NW'(in_ready), NW'(0));
      check("rst_out_valid", NW'(out_valid), NW'(0));
      check("rst_out_last", NW'(out_last), NW'(0));
      check("rst_out_col", out_col, '0);
      exp_q.delete();
      row_q.delete();
      run = 1'b0;
    end else begin
      pend = (exp_q.size() + 7) / 8;
`ifdef DCT8_TPOSE_PINGPONG_EN
      e_ready = run && (pend < 2);
`else
      e_ready = run && (pend == 0);
`endif
      e_valid = (exp_q.size() != 0);
      e_last  = e_valid && ((exp_q.size() % 8) == 1);
      check("in_ready", NW'(in_ready), NW'(e_ready));
      check("out_valid", NW'(out_valid), NW'(e_valid));
      check("out_last", NW'(out_last), NW'(e_last));
      if (e_valid) check("out_col", out_col, exp_q[0]);
      if (e_valid && out_ready) begin
        void'(exp_q.pop_front());
        n_cols++;
      end
      if (e_ready && in_valid) begin
        row_q.push_back(in_row);
        if (row_q.size() == N) begin
          for (int c = 0; c < N; c++) exp_q.push_back(column_of(c));
          row_q.delete();
        end
      end
      run = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [NW-1:0] make_row(input int kind, input int r);
    logic [NW-1:0] row;
    row = '0;
    for (int c = 0; c < N; c++) begin
      case (kind)
        0:       row[c*W +: W] = W'(r * 8 + c);
        1:       row[c*W +: W] = (r == c) ? 16'h8000 : 16'h7FFF;
        default: row[c*W +: W] = W'($urandom);
      endcase
    end
    return row;
  endfunction

  task automatic send_row(input logic [NW-1:0] row, input int max_gap);
    int guard;
    bit hs;
    repeat ($urandom_range(0, max_gap)) @(posedge clk) #1;
    guard    = 0;
    hs       = 1'b0;
    in_row   = row;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!hs && guard < 200);
    if (!hs) check("send_timeout", NW'(0), NW'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int kind, input int max_gap);
    for (int r = 0; r < N; r++) send_row(make_row(kind, r), max_gap);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_timeout", NW'(exp_q.size()), NW'(0));
  endtask

  // ---------------- sequence ----------------
  initial begin
    int  t0;
    int  cycles;
    int  cols0;
    bit  send_done;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;

    // Basic ramp block with downstream always ready
    out_ready = 1'b1;
    send_block(0, 0);
    wait_drain();

    // Signed extremes on the diagonal
    send_block(1, 0);
    wait_drain();

    // Backpressure for 5 cycles at column 3
    out_ready = 1'b0;
    send_block(2, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk) #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk) #1;
    out_ready = 1'b1;
    wait_drain();

`ifndef DCT8_TPOSE_PINGPONG_EN
    // Rows offered while draining must be dropped
    out_ready = 1'b0;
    send_block(2, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_row = make_row(2, k);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    send_block(0, 0);
    wait_drain();
`endif

    // Reset after column 2 of a drain, then a fresh block
    out_ready = 1'b0;
    send_block(2, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk) #1;
    rst_n = 1'b0;
    send_block(2, 0);
    wait_drain();
    check("post_reset_rows", NW'(row_q.size()), NW'(0));

    // Four back-to-back blocks, both sides always ready
    cols0 = n_cols;
    t0    = int'($time);
    for (int b = 0; b < 4; b++) send_block(2, 0);
    cycles = 0;
    while (n_cols < cols0 + 32 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    cycles = (int'($time) - t0) / 10;
    check("b2b_cols", NW'(n_cols - cols0), NW'(32));
`ifdef DCT8_TPOSE_PINGPONG_EN
    check("b2b_cycles_le_42", NW'(cycles <= 42), NW'(1));
`else
    check("b2b_cycles", NW'(cycles), NW'(64));
`endif

    // Random gaps and random downstream stalls
    send_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++) send_block(2, 2);
        send_done = 1'b1;
      end
      begin
        int guard;
        guard = 0;
        while (!(send_done && exp_q.size() == 0) && guard < 2000) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          guard++;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check("final_partial_rows", NW'(row_q.size()), NW'(0));

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
